fht_io_ctrl: RTL
================

FHT_IO_CTRL -- requirements
Module: fht_io_ctrl

Interface
REQ-001 Parameter A_BIT, default 8: bank address width; 4 banks of 2^A_BIT words; frame N = 4*2^A_BIT (1024).
REQ-002 Parameter D_BIT, default 16: sample width.
REQ-003 iCLK  in  1  sole clock; all state updates on the rising edge.
REQ-004 iRESET  in  1  asynchronous, active-low reset.
REQ-005 iIN_VALID  in  1  input sample valid.
REQ-006 iIN_DATA  in  D_BIT  input sample.
REQ-007 oIN_READY  out  1  block accepts a sample this cycle.
REQ-008 oWE  out  1  bank write enable.
REQ-009 oWR_BANK  out  2  bank select for the write.
REQ-010 oWR_ADDR  out  A_BIT  bank write address.
REQ-011 oWR_DATA  out  D_BIT  bank write data.
REQ-012 oRD_BANK  out  2  bank select for the read.
REQ-013 oRD_ADDR  out  A_BIT  bank read address.
REQ-014 iRD_DATA  in  D_BIT  bank read data, valid exactly 1 cycle after the address.
REQ-015 oFHT_START  out  1  one-cycle start pulse to the FHT core.
REQ-016 iFHT_RDY  in  1  core ready; high = idle or done.
REQ-017 oBANK_OWNER  out  1  bank port mux select: 0 = this block, 1 = FHT core.
REQ-018 oOUT_VALID  out  1  output sample valid.
REQ-019 oOUT_DATA  out  D_BIT  output sample.
REQ-020 oOUT_LAST  out  1  marks sample N-1 of the frame.
REQ-021 iOUT_READY  in  1  sink accepts the sample.
REQ-022 oBUSY  out  1  high in every state except IDLE.

Function
REQ-023 FSM states: IDLE, LOAD, START, RUN, UNLOAD.
REQ-024 Sample index k (10-bit counter for the default parameters) maps to bank = k[1:0] and addr = k[A_BIT+1:2]; LOAD and UNLOAD both use this mapping.
REQ-025 IDLE: oIN_READY = 1; a transfer (iIN_VALID & oIN_READY) writes k=0 and moves to LOAD with k=1.
REQ-026 LOAD: oIN_READY = 1; each transfer writes sample k combinationally (oWE = transfer, oWR_* from k and iIN_DATA) and increments k; no write occurs without a transfer.
REQ-027 Transfer at k = N-1 moves to START; oIN_READY = 0 from then until the next IDLE.
REQ-028 START lasts 1 cycle: oFHT_START = 1 and oBANK_OWNER = 1; then RUN.
REQ-029 RUN: oBANK_OWNER = 1; the block arms after first sampling iFHT_RDY = 0, then moves to UNLOAD on the first armed cycle with iFHT_RDY = 1; iFHT_RDY = 1 before arming is ignored.
REQ-030 UNLOAD: oBANK_OWNER = 0; read requests are issued in index order k = 0..N-1.
REQ-031 Unload buffering: 2-entry output FIFO; a read is issued in a cycle only if (FIFO occupancy + reads in flight) < 2, or < 3 when a pop occurs in the same cycle.
REQ-032 Each read's iRD_DATA is pushed into the FIFO on the following cycle.
REQ-033 oOUT_VALID = FIFO non-empty; a pop occurs on oOUT_VALID & iOUT_READY.
REQ-034 oOUT_DATA and oOUT_LAST come from the FIFO head; oOUT_LAST = 1 only on index N-1.
REQ-035 Under backpressure, oOUT_VALID and oOUT_DATA stay stable until accepted; no sample is lost or duplicated.
REQ-036 After the pop of index N-1, return to IDLE next cycle; the FIFO and all counters are zero there.
REQ-037 Throughput: LOAD accepts 1 sample/cycle; UNLOAD delivers 1 sample/cycle while iOUT_READY = 1, first oOUT_VALID 2 cycles after UNLOAD entry.
REQ-038 oWE = 0 and oFHT_START = 0 in all states other than those stated above.
REQ-039 Counters wrap-free: k never exceeds N-1; reaching it always causes the state change defined above.

Reset
REQ-040 iRESET low forces, immediately and from any state: state IDLE, k = 0, FIFO empty, in-flight reads cleared, arm flag cleared.
REQ-041 Outputs while iRESET is low: oIN_READY = 0, oWE = 0, oFHT_START = 0, oBANK_OWNER = 0, oOUT_VALID = 0, oOUT_LAST = 0, oBUSY = 0; data and address outputs = 0.
REQ-042 oIN_READY = 1 in the first cycle after reset release.
REQ-043 Reset during LOAD, RUN or UNLOAD abandons the frame; the next frame restarts at k = 0.

Verification
REQ-044 Continuous-valid load of 1024 samples (data = k) -> writes to bank k%4, addr k/4, 1024 oWE pulses, then one oFHT_START pulse.
REQ-045 Core model holds iFHT_RDY low 5650 cycles, then high -> UNLOAD entered 1 cycle later; oOUT_DATA sequence is 0..1023; oOUT_LAST only on 1023.
REQ-046 iFHT_RDY stuck high in the START cycle and for 3 cycles after -> block stays in RUN until a low then high is seen.
REQ-047 Random iOUT_READY at 30% duty -> all 1024 samples delivered in order, none duplicated, data stable while stalled.
REQ-048 Gapped iIN_VALID at 50% -> exactly 1024 writes; oIN_READY drops after the 1024th transfer.
REQ-049 iRESET asserted at UNLOAD index 500 -> all outputs reach reset values immediately; the next frame loads from k = 0.

Source files
------------

// File: rtl/fht_io_ctrl.sv
// Frame I/O sequencer for an in-place FHT core: loads one frame into four
// interleaved banks, hands the banks to the core, then streams the result out.
//
// state  | meaning
// IDLE   | waiting for the first sample of a frame
// LOAD   | writing samples 1..N-1 into the banks
// START  | one-cycle start pulse, banks handed to the core
// RUN    | core owns the banks; wait for busy-then-ready
// UNLOAD | read banks in index order through a 2-entry output FIFO
module fht_io_ctrl #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iIN_VALID,
  input  logic [D_BIT-1:0] iIN_DATA,
  output logic             oIN_READY,
  output logic             oWE,
  output logic [1:0]       oWR_BANK,
  output logic [A_BIT-1:0] oWR_ADDR,
  output logic [D_BIT-1:0] oWR_DATA,
  output logic [1:0]       oRD_BANK,
  output logic [A_BIT-1:0] oRD_ADDR,
  input  logic [D_BIT-1:0] iRD_DATA,
  output logic             oFHT_START,
  input  logic             iFHT_RDY,
  output logic             oBANK_OWNER,
  output logic             oOUT_VALID,
  output logic [D_BIT-1:0] oOUT_DATA,
  output logic             oOUT_LAST,
  input  logic             iOUT_READY,
  output logic             oBUSY
);

  localparam int K_BIT = A_BIT + 2;
  localparam logic [K_BIT-1:0] K_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_UNLOAD
  } state_t;

  state_t           state, state_nxt;
  logic [K_BIT-1:0] k, k_nxt;
  logic             arm, arm_nxt;
  logic             rd_done, rd_done_nxt;
  logic             rd_pend, rd_pend_last;

  logic [1:0][D_BIT-1:0] fifo_data;
  logic [1:0]            fifo_last;
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;

  logic       in_ready;
  logic       in_xfer;
  logic       pop;
  logic       rd_issue;
  logic [2:0] occ_sum;

  assign in_ready = iRESET && ((state == S_IDLE) || (state == S_LOAD));
  assign in_xfer  = in_ready && iIN_VALID;
  assign pop      = (fifo_cnt != 2'd0) && iOUT_READY;
  assign occ_sum  = {1'b0, fifo_cnt} + {2'b00, rd_pend};

  // A pop in the same cycle frees one slot, so one more read may be in flight.
  assign rd_issue = (state == S_UNLOAD) && !rd_done &&
                    (pop ? (occ_sum < 3'd3) : (occ_sum < 3'd2));

  always_comb begin
    state_nxt   = state;
    k_nxt       = k;
    arm_nxt     = arm;
    rd_done_nxt = rd_done;
    case (state)
      S_IDLE: begin
        if (in_xfer) begin
          k_nxt     = k + 1'b1;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (in_xfer) begin
          if (k == K_LAST) begin
            k_nxt     = '0;
            state_nxt = S_START;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
      end
      S_START: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!arm) begin
          if (!iFHT_RDY) arm_nxt = 1'b1;
        end else if (iFHT_RDY) begin
          arm_nxt   = 1'b0;
          state_nxt = S_UNLOAD;
        end
      end
      S_UNLOAD: begin
        if (rd_issue) begin
          if (k == K_LAST) begin
            k_nxt       = '0;
            rd_done_nxt = 1'b1;
          end else begin
            k_nxt = k + 1'b1;
          end
        end
        if (pop && fifo_last[rd_ptr]) begin
          rd_done_nxt = 1'b0;
          state_nxt   = S_IDLE;
        end
      end
      default: begin
        state_nxt   = S_IDLE;
        k_nxt       = '0;
        arm_nxt     = 1'b0;
        rd_done_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state   <= S_IDLE;
      k       <= '0;
      arm     <= 1'b0;
      rd_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      k       <= k_nxt;
      arm     <= arm_nxt;
      rd_done <= rd_done_nxt;
    end
  end

  // Bank read data lands one cycle after the address, tagged with its last flag.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      fifo_data    <= '0;
      fifo_last    <= '0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      fifo_cnt     <= 2'd0;
    end else begin
      rd_pend      <= rd_issue;
      rd_pend_last <= rd_issue && (k == K_LAST);
      if (rd_pend) begin
        fifo_data[wr_ptr] <= iRD_DATA;
        fifo_last[wr_ptr] <= rd_pend_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  assign oIN_READY   = in_ready;
  assign oWE         = in_xfer;
  assign oWR_BANK    = k[1:0];
  assign oWR_ADDR    = k[K_BIT-1:2];
  assign oWR_DATA    = in_xfer ? iIN_DATA : '0;
  assign oRD_BANK    = (state == S_UNLOAD) ? k[1:0] : 2'b00;
  assign oRD_ADDR    = (state == S_UNLOAD) ? k[K_BIT-1:2] : '0;
  assign oFHT_START  = (state == S_START);
  assign oBANK_OWNER = (state == S_START) || (state == S_RUN);
  assign oOUT_VALID  = (fifo_cnt != 2'd0);
  assign oOUT_DATA   = fifo_data[rd_ptr];
  assign oOUT_LAST   = oOUT_VALID && fifo_last[rd_ptr];
  assign oBUSY       = (state != S_IDLE);

endmodule
